// File: rtl/tone_gen_pkg.sv
// tone_gen_pkg: shared constants, sine table and FSM state type for the tone generator
package tone_gen_pkg;
    localparam int MIN_PERIOD = 16;
    localparam int STEPS      = 16;
    localparam int ACC_W      = 11;
    localparam int PERIOD_W   = 10;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam logic signed [3:0] SINE [STEPS] = '{
        4'sd0, 4'sd3, 4'sd5, 4'sd6, 4'sd7, 4'sd6, 4'sd5, 4'sd3,
        4'sd0, -4'sd3, -4'sd5, -4'sd6, -4'sd7, -4'sd6, -4'sd5, -4'sd3
    };
endpackage

// File: rtl/tone_gen_stepper.sv
// tone_gen_stepper: phase accumulator advancing the sine index 16 times per period clocks
module tone_gen_stepper
    import tone_gen_pkg::*;
(
    input  logic                clk,
    input  logic                RESETn,
    input  logic                en,
    input  logic                clr,
    input  logic [PERIOD_W-1:0] period,
    output logic [3:0]          idx,
    output logic                step,
    output logic                wrap_step
);
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] a;

    // period >= 16 guarantees at most one step per clock
    always_comb begin
        a         = acc + ACC_W'(STEPS);
        step      = en && (a >= ACC_W'(period));
        wrap_step = step && (idx == 4'(STEPS - 1));
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            acc <= '0;
            idx <= '0;
        end else if (clr) begin
            acc <= '0;
            idx <= '0;
        end else if (en) begin
            acc <= step ? a - ACC_W'(period) : a;
            idx <= step ? idx + 4'd1 : idx;
        end
    end
endmodule

// File: rtl/tone_gen.sv
// tone_gen: quantised 16-step sine source with start/stop control and wrap-aligned period reload
module tone_gen
    import tone_gen_pkg::*;
#(
    parameter int DEFAULT_PERIOD = 64
) (
    input  logic                clk,
    input  logic                RESETn,
    input  logic                start,
    input  logic                stop,
    input  logic                load,
    input  logic [PERIOD_W-1:0] period_in,
    output logic signed [3:0]   signal,
    output logic                sample_valid,
    output logic                wrap,
    output logic                load_pending
);
    state_t              state;
    state_t              state_next;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] pend_period;
    logic [PERIOD_W-1:0] clamped;
    logic                pend;
    logic                running;
    logic                clr;
    logic                apply;
    logic [3:0]          idx;
    logic [3:0]          idx_next;
    logic                step;
    logic                wrap_step;

    tone_gen_stepper u_stepper (
        .clk       (clk),
        .RESETn    (RESETn),
        .en        (running),
        .clr       (clr),
        .period    (period),
        .idx       (idx),
        .step      (step),
        .wrap_step (wrap_step)
    );

    // stop beats start; a pending period lands immediately in IDLE, otherwise only at wrap
    always_comb begin
        running    = state != IDLE;
        clamped    = period_in < PERIOD_W'(MIN_PERIOD) ? PERIOD_W'(MIN_PERIOD) : period_in;
        apply      = pend && (!running || wrap_step);
        clr        = (state == IDLE && start && !stop) || (wrap_step && pend);
        idx_next   = clr ? 4'd0 : idx + {3'b0, step};
        state_next = state == IDLE ? ((start && !stop) ? RUN : IDLE)
                   : state == RUN  ? (stop ? FINISH : RUN)
                   : (start && !stop) ? RUN
                   : wrap_step ? IDLE : FINISH;
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state        <= IDLE;
            period       <= PERIOD_W'(DEFAULT_PERIOD);
            pend_period  <= PERIOD_W'(DEFAULT_PERIOD);
            pend         <= 1'b0;
            signal       <= '0;
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
        end else begin
            state        <= state_next;
            if (apply) period <= pend_period;
            if (load) pend_period <= clamped;
            pend         <= load || (pend && !apply);
            signal       <= state_next == IDLE ? 4'sd0 : SINE[idx_next];
            sample_valid <= state_next != IDLE;
            wrap         <= wrap_step;
        end
    end

    assign load_pending = pend;
endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: directed scoreboard bench for tone_gen waveform, cadence, reload and stop behaviour
module tb_tone_gen;
    logic              clk;
    logic              RESETn;
    logic              start;
    logic              stop;
    logic              load;
    logic [9:0]        period_in;
    logic signed [3:0] signal;
    logic              sample_valid;
    logic              wrap;
    logic              load_pending;

    typedef struct {
        int sig;
        int sv;
        int wr;
    } exp_t;

    exp_t q[$];
    int   iv_q[$];
    int   n_asrt = 0;
    int   n_fail = 0;
    int   sine_ref[16] = '{0, 3, 5, 6, 7, 6, 5, 3, 0, -3, -5, -6, -7, -6, -5, -3};

    tone_gen #(.DEFAULT_PERIOD(64)) dut (
        .clk          (clk),
        .RESETn       (RESETn),
        .start        (start),
        .stop         (stop),
        .load         (load),
        .period_in    (period_in),
        .signal       (signal),
        .sample_valid (sample_valid),
        .wrap         (wrap),
        .load_pending (load_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int sig, input int sv, input int wr);
        exp_t e;
        e.sig = sig;
        e.sv  = sv;
        e.wr  = wr;
        q.push_back(e);
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_sig"}, int'(signal), e.sig);
            chk({tag, "_sv"}, int'(sample_valid), e.sv);
            chk({tag, "_wrap"}, int'(wrap), e.wr);
            if (q.size() > 0) tick();
        end
    endtask

    task automatic wait_wrap(output int c);
        c = 0;
        do begin
            tick();
            c++;
        end while (!wrap && c < 2000);
        chk("wrap_seen", int'(wrap), 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic load_idle(input int p);
        period_in = 10'(p);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("load_pend_set", int'(load_pending), 1);
        tick();
        chk("load_pend_idle_clr", int'(load_pending), 0);
    endtask

    task automatic go_idle();
        int w;
        pulse_stop();
        wait_wrap(w);
        chk("idle_sv", int'(sample_valid), 0);
        chk("idle_sig", int'(signal), 0);
    endtask

    task automatic check_interval(input string tag, input int got);
        chk(tag, got, iv_q.pop_front());
    endtask

    initial begin
        int w;
        int sum;
        RESETn = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        load = 1'b0;
        period_in = '0;
        tick();
        tick();
        chk("rst_sig", int'(signal), 0);
        chk("rst_sv", int'(sample_valid), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_lp", int'(load_pending), 0);
        RESETn = 1'b1;
        tick();
        pulse_stop();
        tick();
        chk("stop_idle_sv", int'(sample_valid), 0);
        chk("stop_idle_sig", int'(signal), 0);

        // period 16: one table step per clock, wrap every 16
        load_idle(16);
        pulse_start();
        for (int i = 0; i <= 32; i++) push(sine_ref[i % 16], 1, (i == 16 || i == 32) ? 1 : 0);
        drain("p16");
        go_idle();

        // period 24: no-step, step, step cadence, 240 clocks over ten wraps
        load_idle(24);
        pulse_start();
        push(0, 1, 0); push(0, 1, 0); push(3, 1, 0); push(5, 1, 0);
        push(5, 1, 0); push(6, 1, 0); push(7, 1, 0);
        drain("p24");
        iv_q.push_back(24);
        wait_wrap(w);
        check_interval("p24_first", w + 6);
        iv_q.push_back(240);
        sum = 0;
        for (int i = 0; i < 10; i++) begin
            wait_wrap(w);
            sum += w;
        end
        check_interval("p24_ten", sum);
        go_idle();

        // request below minimum clamps to 16
        load_idle(5);
        pulse_start();
        iv_q.push_back(16);
        iv_q.push_back(16);
        wait_wrap(w);
        check_interval("clamp_first", w);
        wait_wrap(w);
        check_interval("clamp_second", w);
        go_idle();

        // mid-cycle reload: old period finishes, new one from the wrap on
        load_idle(64);
        pulse_start();
        iv_q.push_back(64);
        iv_q.push_back(64);
        iv_q.push_back(32);
        iv_q.push_back(32);
        wait_wrap(w);
        check_interval("p64_first", w);
        repeat (10) tick();
        period_in = 10'd32;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("mid_lp_set", int'(load_pending), 1);
        wait_wrap(w);
        check_interval("mid_old_period", w + 11);
        chk("mid_lp_clr", int'(load_pending), 0);
        wait_wrap(w);
        check_interval("mid_new_1", w);
        wait_wrap(w);
        check_interval("mid_new_2", w);
        go_idle();

        // stop at idx 4 finishes the cycle then idles
        load_idle(16);
        pulse_start();
        for (int i = 0; i <= 4; i++) push(sine_ref[i], 1, 0);
        drain("stop_pre");
        pulse_stop();
        for (int i = 5; i <= 15; i++) push(sine_ref[i], 1, 0);
        push(0, 0, 1);
        push(0, 0, 0);
        drain("stop_fin");

        // start during FINISH resumes without a phase reset
        pulse_start();
        for (int i = 0; i <= 4; i++) push(sine_ref[i], 1, 0);
        drain("resume_pre");
        pulse_stop();
        tick();
        pulse_start();
        for (int i = 7; i <= 17; i++) push(sine_ref[i % 16], 1, (i == 16) ? 1 : 0);
        drain("resume");
        go_idle();

        // async reset mid-run discards pending period and restores default
        pulse_start();
        repeat (3) tick();
        period_in = 10'd40;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("arst_lp_before", int'(load_pending), 1);
        #3 RESETn = 1'b0;
        #1;
        chk("arst_sig", int'(signal), 0);
        chk("arst_sv", int'(sample_valid), 0);
        chk("arst_lp", int'(load_pending), 0);
        chk("arst_wrap", int'(wrap), 0);
        tick();
        RESETn = 1'b1;
        tick();
        pulse_start();
        iv_q.push_back(64);
        wait_wrap(w);
        check_interval("arst_default_period", w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
